// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing from a CLK_DIV-divided board clock.
// Ports: clk, reset (sync, active-high) in; hCount, vCount, bright, hSync, vSync,
// pixel_tick, frame_start out. Define VGA_SYNC_ACTIVE_HIGH_EN for active-high syncs.
module vga_timing_gen #(
  parameter int CLK_DIV     = 4,
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_VIS_START = 144,
  parameter int H_VIS_END   = 784,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_VIS_START = 35,
  parameter int V_VIS_END   = 515
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       bright,
  output logic       hSync,
  output logic       vSync,
  output logic       pixel_tick,
  output logic       frame_start
);

  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_PRE  = DW'(CLK_DIV - 2);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_S    = 10'(H_SYNC);
  localparam logic [9:0] V_S    = 10'(V_SYNC);
  localparam logic [9:0] H_VS   = 10'(H_VIS_START);
  localparam logic [9:0] H_VE   = 10'(H_VIS_END);
  localparam logic [9:0] V_VS   = 10'(V_VIS_START);
  localparam logic [9:0] V_VE   = 10'(V_VIS_END);

`ifdef VGA_SYNC_ACTIVE_HIGH_EN
  localparam logic SYNC_ON = 1'b1;
`else
  localparam logic SYNC_ON = 1'b0;
`endif

  logic [DW-1:0] r_div;
  logic [9:0]    r_h;
  logic [9:0]    r_v;
  logic          r_bright;
  logic          r_hs;
  logic          r_vs;
  logic          r_tick;
  logic          r_fs;

  logic          w_h_last;
  logic          w_v_last;
  logic          w_div_pre;
  logic [9:0]    w_h_nxt;
  logic [9:0]    w_v_nxt;
  logic          w_bright_nxt;
  logic          w_hs_nxt;
  logic          w_vs_nxt;

  assign w_h_last  = (r_h == H_LAST);
  assign w_v_last  = (r_v == V_LAST);
  assign w_div_pre = (r_div == DIV_PRE);

  // Next raster position, applied only on a pixel_tick cycle.
  always_comb begin
    w_h_nxt = r_h + 10'd1;
    w_v_nxt = r_v;
    if (w_h_last) begin
      w_h_nxt = 10'd0;
      w_v_nxt = w_v_last ? 10'd0 : r_v + 10'd1;
    end
  end

  // Decodes use the next position so they line up with the counters.
  assign w_bright_nxt = (w_h_nxt >= H_VS) && (w_h_nxt < H_VE) &&
                        (w_v_nxt >= V_VS) && (w_v_nxt < V_VE);
  assign w_hs_nxt = (w_h_nxt < H_S) ? SYNC_ON : ~SYNC_ON;
  assign w_vs_nxt = (w_v_nxt < V_S) ? SYNC_ON : ~SYNC_ON;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div    <= '0;
      r_h      <= '0;
      r_v      <= '0;
      r_bright <= 1'b0;
      r_hs     <= SYNC_ON;
      r_vs     <= SYNC_ON;
      r_tick   <= 1'b0;
      r_fs     <= 1'b0;
    end else begin
      r_div  <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
      // Tick is high for the cycle in which div sits at CLK_DIV-1.
      r_tick <= w_div_pre;
      // Frame start rides on the tick that wraps the last pixel.
      r_fs   <= w_div_pre && w_h_last && w_v_last;
      if (r_tick) begin
        r_h      <= w_h_nxt;
        r_v      <= w_v_nxt;
        r_bright <= w_bright_nxt;
        r_hs     <= w_hs_nxt;
        r_vs     <= w_vs_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (r_h < 10'(H_TOTAL));
      assert (r_v < 10'(V_TOTAL));
    end
  end

  assign hCount      = r_h;
  assign vCount      = r_v;
  assign bright      = r_bright;
  assign hSync       = r_hs;
  assign vSync       = r_vs;
  assign pixel_tick  = r_tick;
  assign frame_start = r_fs;

endmodule
